// File: rtl/apu_mixer_pkg.sv
// Shared types and helpers for the APU output mixer.
package apu_mixer_pkg;

    typedef logic signed [4:0]  dac_t;
    typedef logic signed [7:0]  sum_t;
    typedef logic signed [10:0] prod_t;
    typedef logic signed [15:0] sample_t;

    localparam int unsigned OUT_SHIFT = 5;

    // Bipolar DAC: code 0..15 maps to -15..+15 in steps of 2; disabled reads as 0.
    function automatic dac_t dac_term(input logic [3:0] code, input logic en);
        dac_t t;
        t = en ? (dac_t'({code, 1'b0}) - dac_t'(5'd15)) : '0;
        return t;
    endfunction

endpackage

// File: rtl/apu_mixer_side.sv
// One output side of the mixer: pan/sum, volume multiply, box-car accumulator
// and output register. Optional DC-blocking filter under APU_MIXER_HPF_EN.
module apu_mixer_side
    import apu_mixer_pkg::*;
#(
    parameter int unsigned DECIM_LOG2 = 2
`ifdef APU_MIXER_HPF_EN
    ,
    parameter int unsigned HPF_SHIFT  = 8
`endif
) (
    input  logic    clk,
    input  logic    rst_n,
    input  dac_t    term [4],
    input  logic [3:0] pan,
    input  dac_t    vin_term,
    input  logic [2:0] nvolume,
    input  logic    acc_en,
    input  logic    load,
    output sample_t sample
);

    localparam int unsigned AccW = 11 + DECIM_LOG2;

    sum_t       sum_d, sum_q;
    logic [3:0] mult_d, mult_q;
    prod_t      prod_d, prod_q;

    logic signed [AccW-1:0] acc_q, acc_sum, avg;
    sample_t                x, y;

    always_comb begin
        sum_d = sum_t'(vin_term);
        for (int n = 0; n < 4; n++) begin
            if (pan[n]) begin
                sum_d = sum_d + sum_t'(term[n]);
            end
        end
        mult_d = {1'b0, ~nvolume} + 4'd1;
    end

    always_comb begin
        prod_d  = prod_t'(sum_q) * prod_t'({1'b0, mult_q});
        acc_sum = acc_q + AccW'(prod_q);
        avg     = acc_sum >>> DECIM_LOG2;
        // Averages stay within +-600, so widening the whole accumulator is exact.
        x       = sample_t'(avg) <<< OUT_SHIFT;
    end

`ifdef APU_MIXER_HPF_EN
    logic signed [23:0] cap_q, cap_d;
    logic signed [17:0] diff;

    always_comb begin
        diff = 18'(x) - 18'(cap_q >>> 8);
        if (diff > 18'sd32767) begin
            y = 16'sh7fff;
        end else if (diff < -18'sd32768) begin
            y = 16'sh8000;
        end else begin
            y = sample_t'(diff);
        end
        cap_d = cap_q + (24'(y) <<< (8 - HPF_SHIFT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= '0;
        end else if (load) begin
            cap_q <= cap_d;
        end
    end
`else
    always_comb begin
        y = x;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            mult_q <= '0;
            prod_q <= '0;
            acc_q  <= '0;
            sample <= '0;
        end else begin
            sum_q  <= sum_d;
            mult_q <= mult_d;
            prod_q <= prod_d;
            if (acc_en) begin
                acc_q <= load ? '0 : acc_sum;
            end
            if (load) begin
                sample <= y;
            end
        end
    end

endmodule

// File: rtl/apu_mixer.sv
// APU output mixer: NR51 panning, NR50 volume and box-car decimation to
// signed 16-bit PCM. Optional high-pass filter enabled by APU_MIXER_HPF_EN.
module apu_mixer
    import apu_mixer_pkg::*;
#(
    parameter int unsigned DECIM_LOG2 = 2,
    parameter int unsigned HPF_SHIFT  = 8
) (
    input  logic       apuv_4mhz,
    input  logic       napu_reset,
    input  logic       sample_tick,
    input  logic [3:0] ch1_dac,
    input  logic [3:0] ch2_dac,
    input  logic [3:0] ch3_dac,
    input  logic [3:0] ch4_dac,
    input  logic [3:0] ch_dac_en,
    input  logic [3:0] vin_level,
    input  logic [3:0] rmixer,
    input  logic [3:0] lmixer,
    input  logic [2:0] nrvolume,
    input  logic [2:0] nlvolume,
    input  logic       vin_r_ena,
    input  logic       vin_l_ena,
    output sample_t    left_out,
    output sample_t    right_out,
    output logic       out_valid
);

    localparam int unsigned CntW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((1 << DECIM_LOG2) - 1);

    if (HPF_SHIFT < 1 || HPF_SHIFT > 8 || DECIM_LOG2 > 4) begin : g_param_check
        $error("apu_mixer: parameter out of range");
    end

    dac_t       term_q [4];
    dac_t       vin_r_q, vin_l_q;
    logic [3:0] rpan_q, lpan_q;
    logic [2:0] nrvol_q, nlvol_q;
    logic       v1_q, v2_q, v3_q;
    logic [CntW-1:0] cnt_q;
    logic       wrap, load;

    assign wrap = (cnt_q == CntLast);
    assign load = v3_q && wrap;

    always_ff @(posedge apuv_4mhz or negedge napu_reset) begin
        if (!napu_reset) begin
            for (int n = 0; n < 4; n++) begin
                term_q[n] <= '0;
            end
            vin_r_q   <= '0;
            vin_l_q   <= '0;
            rpan_q    <= '0;
            lpan_q    <= '0;
            nrvol_q   <= '0;
            nlvol_q   <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            v1_q      <= sample_tick;
            v2_q      <= v1_q;
            v3_q      <= v2_q;
            out_valid <= load;
            if (sample_tick) begin
                term_q[0] <= dac_term(ch1_dac, ch_dac_en[0]);
                term_q[1] <= dac_term(ch2_dac, ch_dac_en[1]);
                term_q[2] <= dac_term(ch3_dac, ch_dac_en[2]);
                term_q[3] <= dac_term(ch4_dac, ch_dac_en[3]);
                vin_r_q   <= dac_term(vin_level, vin_r_ena);
                vin_l_q   <= dac_term(vin_level, vin_l_ena);
                rpan_q    <= rmixer;
                lpan_q    <= lmixer;
                nrvol_q   <= nrvolume;
                nlvol_q   <= nlvolume;
            end
            // Shared window counter keeps both sides' decimation phase locked.
            if (v3_q) begin
                cnt_q <= wrap ? '0 : cnt_q + 1'b1;
            end
        end
    end

    apu_mixer_side #(
        .DECIM_LOG2 (DECIM_LOG2)
`ifdef APU_MIXER_HPF_EN
        ,
        .HPF_SHIFT  (HPF_SHIFT)
`endif
    ) u_left (
        .clk      (apuv_4mhz),
        .rst_n    (napu_reset),
        .term     (term_q),
        .pan      (lpan_q),
        .vin_term (vin_l_q),
        .nvolume  (nlvol_q),
        .acc_en   (v3_q),
        .load     (load),
        .sample   (left_out)
    );

    apu_mixer_side #(
        .DECIM_LOG2 (DECIM_LOG2)
`ifdef APU_MIXER_HPF_EN
        ,
        .HPF_SHIFT  (HPF_SHIFT)
`endif
    ) u_right (
        .clk      (apuv_4mhz),
        .rst_n    (napu_reset),
        .term     (term_q),
        .pan      (rpan_q),
        .vin_term (vin_r_q),
        .nvolume  (nrvol_q),
        .acc_en   (v3_q),
        .load     (load),
        .sample   (right_out)
    );

endmodule

// File: doc/apu_mixer.md
Name: apu_mixer

Overview:
- Downstream consumer of the APU control stage (NR50/NR51/NR52).
- Takes the four channel DAC codes plus cartridge VIN, and applies NR51 panning (rmixer/lmixer) and NR50 master volume (nrvolume/nlvolume, inverted; vin_r_ena/vin_l_ena).
- Produces signed 16-bit left/right PCM samples with a valid strobe. Samples are decimated by box-car averaging for the host-side audio sink.
- Fully pipelined on the APU 4 MHz clock. Advances only on sample ticks.

Parameters:
- DECIM_LOG2, 2, log2 of the number of sample ticks averaged per output sample (0..4).
- HPF_SHIFT, 8, high-pass time-constant shift, 1..8. Used only with APU_MIXER_HPF_EN.

Ports:
- apuv_4mhz  in  1  APU clock.
- napu_reset  in  1  asynchronous active-low reset.
- sample_tick  in  1  one-cycle pulse per DAC sample (1 MHz rate, derived from dyfa_1mhz).
- ch1_dac, ch2_dac, ch3_dac, ch4_dac  in  4 each  channel DAC codes 0..15.
- ch_dac_en  in  4  per-channel DAC enable; bit n = channel n+1.
- vin_level  in  4  VIN code 0..15.
- rmixer, lmixer  in  4 each  NR51 pan bits; bit n = channel n+1.
- nrvolume, nlvolume  in  3 each  inverted NR50 volume.
- vin_r_ena, vin_l_ena  in  1 each  NR50 VIN routing.
- left_out, right_out  out  16  signed samples.
- out_valid  out  1  one-cycle pulse when left_out/right_out update.

Behaviour:
- Reset: asynchronous, active-low, on napu_reset.
  - left_out = right_out = 0 and out_valid = 0.
  - All pipeline valids, the accumulators, and the tick counter are cleared to 0.
  - HPF state is cleared to 0.
- DAC conversion: term = en ? (2*code − 15) : 0, giving a 5-bit signed value in −15..+15.
  - Channel en = ch_dac_en[n].
  - VIN uses code vin_level, with en = vin_x_ena for that side.
- Stage 1 (edge where sample_tick = 1): register all terms, pan bits, volumes, and v1 = 1. Otherwise v1 = 0.
- Stage 2: per side, sum = Σ(term AND pan bit) + VIN term. 8-bit signed, range −75..+75. Register with v2 = v1.
- Stage 3: product = sum × (vol+1), where vol = ~nvolume, so the multiplier is 1..8. 11-bit signed, ±600.
  - Add the product into a (11+DECIM_LOG2)-bit signed accumulator.
  - Increment the DECIM_LOG2-bit tick counter; it wraps at 2^DECIM_LOG2.
- Window completion: on the stage-3 cycle where the counter wraps:
  - avg = (acc + product) >>> DECIM_LOG2 (arithmetic shift).
  - Load left_out/right_out = sign-extend(avg) <<< 5.
  - Pulse out_valid for that cycle.
  - Accumulator restarts at 0.
- Latency: out_valid is high in the cycle following the 3rd edge after the edge that captured the window's final tick.
- Back-to-back ticks (every cycle) are legal, with no stalls and no lost ticks.
- Ticks while stage 1 is busy: stage 1 simply reloads, since every stage advances each clock.
- Outputs hold their value between out_valid pulses.
- DECIM_LOG2 = 0: every tick produces an output, with no averaging.
- Register inputs (pan, volume, enables) changing mid-window: each tick uses the values captured at its own stage 1.
- Reset mid-window: the partial accumulation is discarded. After release, the first output requires a full 2^DECIM_LOG2 ticks.
- No saturation is needed: the max magnitude is 600 << 5 = 19200, which fits 16 bits.

Optional Feature:
- Macro: APU_MIXER_HPF_EN.
- Defined: DC-blocking high-pass per side, evaluated in the output-load cycle, with no added latency.
  - x = pre-HPF sample.
  - y = sat16(x − (cap >>> 8)).
  - cap (24-bit signed) <= cap + (y <<< (8 − HPF_SHIFT)).
  - Output y.
  - cap resets to 0 and updates only on out_valid.
- Undefined: no cap registers; output = x.

Decomposition:
- Package apu_mixer_pkg:
  - typedefs dac_t (signed 5), sum_t (signed 8), prod_t (signed 11), sample_t (signed 16).
  - constant OUT_SHIFT = 5.
  - function dac_term(code, en).
- Sub-module apu_mixer_side: stages 2–3, the accumulator, and the optional HPF for one side.
  - Instantiated twice (left, right).
  - The tick counter lives in the top level so both sides share one counter.

Test Plan:
- Reset: hold napu_reset low, toggle clock and ticks -> outputs 0, out_valid 0. After release, no out_valid until 4 ticks (DECIM_LOG2 = 2).
- Single channel: ch1_dac = 15, ch_dac_en = 0001, rmixer = 0001, lmixer = 0000, nrvolume = 000, 4 ticks -> right_out = 3840, left_out = 0, one out_valid pulse 3 edges after the 4th tick capture.
- Full negative: all codes 0, ch_dac_en = 1111, rmixer = lmixer = 1111, nrvolume = nlvolume = 111, VIN off -> both outputs −1920.
- Disabled DAC and VIN: ch2_dac = 15 with ch_dac_en[1] = 0, panned -> contributes 0. vin_level = 0 with vin_l_ena = 1, nlvolume = 111 -> left_out = −480.
- Averaging and back-to-back: sample_tick high every cycle, ch1 alternating codes 15/0 (+15/−15), right panned, nrvolume = 111 -> right_out = 0, out_valid every 4th cycle.
- Mid-window reset: 2 ticks with ch1 = 15, pulse napu_reset, then 4 ticks with ch1 = 0 -> first output −480 (right, vol ×1), no stale contribution. With APU_MIXER_HPF_EN: constant 3840 input -> first output 3840, then monotonically decaying toward 0.
